fetch_queue: RTL

Instruction fetch stage for the pipelined MIPS core, sitting directly upstream of the IF/ID pipeline register. Owns the fetch PC, issues pipelined word reads to instruction memory over a valid/ready request channel with in-order responses, and buffers returned instructions in a small queue. Hands IF/ID one instruction plus its PC+4 per cycle unless decode stalls. Accepts a redirect from the branch/jump logic that flushes buffered and in-flight instructions.

---
 rtl/fetch_queue_pkg.sv | 19 +
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue_fifo.sv | 58 +++++
 rtl/fetch_queue.sv | 132 +++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared defaults and types for the instruction fetch queue
//
// Purpose: default DEPTH / RESET_PC, instruction word width, NOP word and the
//          queue entry layout shared by fetch_queue, fetch_fifo and fetch_queue_if.
// Ports:   none (package).
package fetch_queue_pkg;

  localparam int                FQ_DEPTH    = 4;
  localparam logic [31:0]       FQ_RESET_PC = 32'h0000_0000;
  localparam int                INSTR_W     = 32;
  // MIPS "sll $0,$0,0"; also what IF/ID sees while the queue is empty.
  localparam logic [INSTR_W-1:0] NOP_WORD   = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction memory request/response channel
//
// Purpose: pipelined word-read channel between the fetch stage and instruction memory.
// Ports:   req_valid/req_ready/req_addr  request handshake (fetch -> memory)
//          rsp_valid/rsp_data            in-order read data, one pulse per accepted request
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [31:0]        req_addr;
  logic               rsp_valid;
  logic [INSTR_W-1:0] rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - synchronous FIFO holding fetched {instr, pc} entries
//
// Purpose: DEPTH-entry FIFO (DEPTH a power of two) with push, pop, flush, count and
//          head outputs. Flush dominates push; pop of an empty FIFO is ignored; push
//          while full is accepted only together with a pop.
// Ports:   clk, rst (async active-low), flush, push, push_data, pop,
//          head (entry at read pointer), count (0..DEPTH), empty.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fq_entry_t     push_data,
  input  logic          pop,
  output fq_entry_t     head,
  output logic [CW-1:0] count,
  output logic          empty
);

  fq_entry_t       store [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = store[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - MIPS instruction fetch stage with request credit and fetch queue
//
// Purpose: owns the fetch PC, issues pipelined word reads, buffers returned words and
//          presents one {instr, pc+4} per cycle to IF/ID. A redirect flushes the queue
//          and discards responses still in flight.
// Params:  DEPTH (queue entries and credit limit, power of two 2..16), RESET_PC.
// Ports:   clk, rst (async active-low)
//          redirect, redirect_pc  restart fetch at redirect_pc (low two bits ignored)
//          stall                  decode does not take an instruction this cycle
//          mem                    instruction memory channel (fetch_queue_if.master)
//          out_valid, out_instr, out_pcadd  instruction and its address + 4 to IF/ID
// Config:  FETCH_QUEUE_BYPASS_EN - when defined, a response arriving into an empty queue
//          is presented combinationally in the same cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               stall,
  fetch_queue_if.master      mem,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pcadd
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fpc;
  logic [31:0]   rpc;
  logic [31:0]   redirect_addr;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] kill;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   in_use;
  logic          run;
  logic          fifo_empty;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_keep;
  logic          bypass_pop;
  logic          push;
  logic          pop;
  fq_entry_t     head;
  fq_entry_t     push_entry;

  assign redirect_addr = redirect_pc & 32'hFFFF_FFFC;

  // Credit: in-flight plus buffered never exceeds DEPTH, so every response has a slot.
  // run holds requests off until the first cycle after reset release.
  assign in_use        = {1'b0, outstanding} + {1'b0, fifo_count};
  assign mem.req_valid = run && !redirect && (in_use < (CW+1)'(DEPTH));
  assign mem.req_addr  = fpc;
  assign req_fire      = mem.req_valid && mem.req_ready;

  // A response with nothing outstanding is a protocol error and is dropped.
  assign rsp_take = mem.rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_take && (kill == '0) && !redirect;

  assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_take);

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass     = fifo_empty && rsp_keep;
  assign bypass_pop = bypass && !stall;
`else
  assign bypass_pop = 1'b0;
`endif

  assign push             = rsp_keep && !bypass_pop;
  assign pop              = !fifo_empty && !stall && !redirect;
  assign push_entry.instr = mem.rsp_data;
  assign push_entry.pc    = rpc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_comb begin
    out_valid = !fifo_empty;
    out_instr = head.instr;
    out_pcadd = head.pc + 32'd4;
    if (fifo_empty) begin
      out_instr = NOP_WORD;
      out_pcadd = '0;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypass) begin
      out_valid = 1'b1;
      out_instr = mem.rsp_data;
      out_pcadd = rpc + 32'd4;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run         <= 1'b0;
      fpc         <= RESET_PC;
      rpc         <= RESET_PC;
      outstanding <= '0;
      kill        <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding_next;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        fpc  <= redirect_addr;
        rpc  <= redirect_addr;
        kill <= outstanding_next;
      end else begin
        if (req_fire)                     fpc  <= fpc + 32'd4;
        if (rsp_take && (kill != '0))     kill <= kill - CW'(1);
        if (rsp_keep)                     rpc  <= rpc + 32'd4;
      end
    end
  end

endmodule
